scan_selector: RTL and testbench
================================

SCAN_SELECTOR -- requirements
Module: scan_selector

Interface
REQ-001 Parameter WIDTH, default 8, bit width of one channel.
REQ-002 Parameter CHANNELS, default 8, channel count, legal range 2..16.
REQ-003 Parameter SEL_W, default 3, select width; SHALL equal ceil(log2(CHANNELS)).
REQ-004 Parameter DWELL, default 4, auto-mode cycles per sample, legal range 1..255.
REQ-005 iClk  in  1  single clock; all state updates on rising edge.
REQ-006 iRst  in  1  asynchronous, active-high reset.
REQ-007 iData  in  CHANNELS*WIDTH  flattened channels; channel k = iData[k*WIDTH +: WIDTH].
REQ-008 iMode  in  1  0 = manual select, 1 = auto scan.
REQ-009 iSel  in  SEL_W  manual channel select.
REQ-010 iMask  in  CHANNELS  auto-scan enable per channel; bit k = 1 includes channel k.
REQ-011 iReady  in  1  consumer accepts oData when high with oValid high.
REQ-012 oData  out  WIDTH  registered selected sample.
REQ-013 oChan  out  SEL_W  index of channel held in oData.
REQ-014 oValid  out  1  oData/oChan hold an unconsumed sample.
REQ-015 oErr  out  1  one-cycle pulse: manual select out of range.

Function
REQ-016 Slot free (load) SHALL be: !oValid || iReady; a sample is consumed when oValid && iReady.
REQ-017 While oValid && !iReady, oData, oChan, oValid SHALL hold unchanged regardless of iData, iSel, iMode, iMask.
REQ-018 Manual (iMode=0), load, iSel < CHANNELS: next edge oData <= channel iSel, oChan <= iSel, oValid <= 1 (latency 1 cycle).
REQ-019 Manual, load, iSel >= CHANNELS: no capture, oValid <= 0, oErr <= 1 for one cycle; oData/oChan hold.
REQ-020 Auto (iMode=1): internal pointer ptr (SEL_W bits) and dwell counter cnt (8 bits).
REQ-021 cnt SHALL increment each cycle while below DWELL-1 and saturate at DWELL-1.
REQ-022 Issue slot: iMode=1, cnt == DWELL-1, load high; otherwise in auto mode with load high and no issue, oValid <= 0.
REQ-023 Issue slot with iMask[ptr]=1: oData <= channel ptr, oChan <= ptr, oValid <= 1, cnt <= 0, ptr <= next enabled index after ptr.
REQ-024 Issue slot with iMask[ptr]=0: no sample, oValid <= 0, cnt held, ptr <= next enabled index after ptr.
REQ-025 Next-enabled search SHALL be circular: ptr+1 .. CHANNELS-1, then 0 .. ptr; wraps from CHANNELS-1 to 0.
REQ-026 Single enabled channel k: every issue slot samples k, ptr stays k.
REQ-027 iMask all zero: no samples, ptr and cnt hold, oValid falls after pending sample consumed.
REQ-028 Mode change manual->auto: cnt <= 0, ptr retained; auto->manual: ptr, cnt retained; pending oValid sample unaffected.
REQ-029 Consume and new capture in the same cycle SHALL produce back-to-back samples with oValid staying 1.
REQ-030 DWELL=1 with iReady held high SHALL issue one sample per cycle.

Reset
REQ-031 iRst high SHALL immediately force oData=0, oChan=0, oValid=0, oErr=0, ptr=0, cnt=0, independent of iClk.
REQ-032 Reset asserted mid-stall SHALL discard the pending sample; first capture occurs on the first load edge after iRst falls.

Verification
REQ-033 Manual sweep: WIDTH=8, CHANNELS=8, channel k = 8'hF0+k, iReady=1, iSel 0..7 one per cycle -> oData F0..F7, oChan 0..7, each one cycle after iSel.
REQ-034 Stall: manual iSel=3 captured, iReady=0 for 5 cycles while iSel=5 and iData change -> oData=F3, oChan=3, oValid=1 stable; iReady=1 -> next cycle oChan=5.
REQ-035 Auto scan: DWELL=4, iMask=8'b1010_0101, iReady=1 -> oChan sequence 0,2,5,7,0 with oValid high one cycle in every 4.
REQ-036 Mask edge: iMask=0 for 20 cycles -> oValid=0 throughout, ptr unchanged; then iMask=8'b0100_0000 -> only oChan=6 samples.
REQ-037 Manual out-of-range: CHANNELS=6, iSel=7 -> oErr one-cycle pulse, oValid=0, oData unchanged.
REQ-038 Reset mid-stall: oValid=1, iReady=0, pulse iRst between clock edges -> all outputs 0 before next edge; auto scan restarts at channel 0 after DWELL cycles.

Source files
------------

// File: rtl/scan_selector_if.sv
// Bus bundle for scan_selector: channel inputs, scan controls and the output sample handshake.
// The DUT connects through the slave modport; whatever drives the inputs uses master.
interface scan_selector_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3
);
  logic [CHANNELS*WIDTH-1:0] iData;
  logic                      iMode;
  logic [SEL_W-1:0]          iSel;
  logic [CHANNELS-1:0]       iMask;
  logic                      iReady;
  logic [WIDTH-1:0]          oData;
  logic [SEL_W-1:0]          oChan;
  logic                      oValid;
  logic                      oErr;

  modport master (
    output iData, iMode, iSel, iMask, iReady,
    input  oData, oChan, oValid, oErr
  );

  modport slave (
    input  iData, iMode, iSel, iMask, iReady,
    output oData, oChan, oValid, oErr
  );
endinterface

// File: rtl/scan_selector.sv
// Channel selector with manual select or dwell-timed auto scan over a channel mask,
// presenting one registered sample at a time behind a valid/ready handshake.
module scan_selector #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3,
  parameter int DWELL    = 4
) (
  input  logic          iClk,
  input  logic          iRst,
  scan_selector_if.slave bus
);
  localparam logic [7:0] CNT_TC = 8'(DWELL - 1);

  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             mode_q;
  logic             load;

  logic [WIDTH-1:0] chans [CHANNELS];

  for (genvar k = 0; k < CHANNELS; k++) begin : g_split
    assign chans[k] = bus.iData[k*WIDTH +: WIDTH];
  end

  // Circular search starting just after p; p itself is the last candidate.
  function automatic logic [SEL_W-1:0] next_enabled(input logic [SEL_W-1:0] p,
                                                    input logic [CHANNELS-1:0] m);
    logic [SEL_W-1:0] r;
    logic [SEL_W-1:0] idx_s;
    logic             found;
    int               idx;
    r     = p;
    found = 1'b0;
    for (int i = 1; i <= CHANNELS; i++) begin
      idx   = (int'(p) + i) % CHANNELS;
      idx_s = SEL_W'(idx);
      if (!found && m[idx_s]) begin
        r     = idx_s;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    load    = !valid_q || bus.iReady;

    if (!bus.iMode) begin
      if (load) begin
        if (int'(bus.iSel) < CHANNELS) begin
          data_d  = chans[bus.iSel];
          chan_d  = bus.iSel;
          valid_d = 1'b1;
        end else begin
          valid_d = 1'b0;
          err_d   = 1'b1;
        end
      end
    end else if (!mode_q) begin
      // First auto cycle after manual restarts the dwell; no issue this cycle.
      cnt_d = 8'd0;
      if (load) valid_d = 1'b0;
    end else if (load && (cnt_q == CNT_TC)) begin
      ptr_d = next_enabled(ptr_q, bus.iMask);
      if (bus.iMask[ptr_q]) begin
        data_d  = chans[ptr_q];
        chan_d  = ptr_q;
        valid_d = 1'b1;
        cnt_d   = 8'd0;
      end else begin
        valid_d = 1'b0;
      end
    end else begin
      if (load) valid_d = 1'b0;
      if (cnt_q != CNT_TC) cnt_d = cnt_q + 8'd1;
    end
  end

  // mode_q resets to auto so a scan running out of reset starts its dwell immediately.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= 8'd0;
      mode_q  <= 1'b1;
    end else begin
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      mode_q  <= bus.iMode;
    end
  end

  assign bus.oData  = data_q;
  assign bus.oChan  = chan_q;
  assign bus.oValid = valid_q;
  assign bus.oErr   = err_q;
endmodule

// File: tb/tb_scan_selector.sv
// Bench for scan_selector: table-driven manual vectors, directed auto/mask/reset sequences,
// and randomized traffic checked against a rule-level reference model.
module tb_scan_selector;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scan_selector_if #(.WIDTH(8), .CHANNELS(8), .SEL_W(3)) bus ();
  scan_selector_if #(.WIDTH(8), .CHANNELS(6), .SEL_W(3)) bus6 ();

  scan_selector #(.WIDTH(8), .CHANNELS(8), .SEL_W(3), .DWELL(4)) dut (
    .iClk(clk), .iRst(rst), .bus(bus)
  );
  scan_selector #(.WIDTH(8), .CHANNELS(6), .SEL_W(3), .DWELL(1)) dut6 (
    .iClk(clk), .iRst(rst), .bus(bus6)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (default instance: 8 channels, dwell 4)
  int m_valid, m_data, m_chan, m_err, m_ptr, m_cnt, m_prev;

  typedef struct {
    logic       mode;
    logic [2:0] sel;
    logic       ready;
    logic [7:0] base;
    logic [7:0] exp_data;
    logic [2:0] exp_chan;
    logic       exp_valid;
  } vec_t;
  vec_t tbl[15];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_chan = 0; m_err = 0;
    m_ptr = 0; m_cnt = 0; m_prev = 1;
  endtask

  function automatic int ch_data(int k);
    return int'(bus.iData[k*8 +: 8]);
  endfunction

  task automatic model_step();
    int load, nxt;
    int en[$];
    load  = (!m_valid || bus.iReady) ? 1 : 0;
    m_err = 0;
    if (!bus.iMode) begin
      if (load != 0) begin
        if (int'(bus.iSel) < 8) begin
          m_valid = 1; m_data = ch_data(int'(bus.iSel)); m_chan = int'(bus.iSel);
        end else begin
          m_valid = 0; m_err = 1;
        end
      end
    end else if (m_prev == 0) begin
      m_cnt = 0;
      if (load != 0) m_valid = 0;
    end else if (load != 0 && m_cnt == 3) begin
      for (int k = 0; k < 8; k++) if (bus.iMask[k]) en.push_back(k);
      nxt = m_ptr;
      if (en.size() > 0) begin
        nxt = en[0];
        foreach (en[i]) if (en[i] > m_ptr) begin nxt = en[i]; break; end
      end
      if (bus.iMask[m_ptr]) begin
        m_valid = 1; m_data = ch_data(m_ptr); m_chan = m_ptr; m_cnt = 0;
      end else begin
        m_valid = 0;
      end
      m_ptr = nxt;
    end else begin
      if (load != 0) m_valid = 0;
      if (m_cnt < 3) m_cnt++;
    end
    m_prev = bus.iMode ? 1 : 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [7:0] base);
    for (int k = 0; k < 8; k++) bus.iData[k*8 +: 8] = base + 8'(k);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_seq[5];
    int ns, last_t, n6, t_valid;
    exp_seq = '{0, 2, 5, 7, 0};

    rst = 1'b1;
    bus.iData = '0; bus.iMode = 1'b0; bus.iSel = '0; bus.iMask = '0; bus.iReady = 1'b0;
    bus6.iData = '0; bus6.iMode = 1'b0; bus6.iSel = '0; bus6.iMask = '0; bus6.iReady = 1'b0;
    @(posedge clk);
    #1;
    check("rst_data", int'(bus.oData), 0);
    check("rst_chan", int'(bus.oChan), 0);
    check("rst_valid", int'(bus.oValid), 0);
    check("rst_err", int'(bus.oErr), 0);
    check("rst6_valid", int'(bus6.oValid), 0);
    rst = 1'b0;
    model_reset();

    // Manual sweep, then stall with changing inputs, then release
    for (int k = 0; k < 8; k++)
      tbl[k] = '{1'b0, 3'(k), 1'b1, 8'hF0, 8'(8'hF0 + k), 3'(k), 1'b1};
    tbl[8] = '{1'b0, 3'd3, 1'b1, 8'hF0, 8'hF3, 3'd3, 1'b1};
    for (int i = 0; i < 5; i++)
      tbl[9+i] = '{1'b0, 3'd5, 1'b0, 8'(8'h10 + 8'h10*i), 8'hF3, 3'd3, 1'b1};
    tbl[14] = '{1'b0, 3'd5, 1'b1, 8'h60, 8'h65, 3'd5, 1'b1};
    for (int i = 0; i < 15; i++) begin
      bus.iMode = tbl[i].mode; bus.iSel = tbl[i].sel; bus.iReady = tbl[i].ready;
      set_data(tbl[i].base);
      tick();
      check($sformatf("vec%0d_data", i), int'(bus.oData), int'(tbl[i].exp_data));
      check($sformatf("vec%0d_chan", i), int'(bus.oChan), int'(tbl[i].exp_chan));
      check($sformatf("vec%0d_valid", i), int'(bus.oValid), int'(tbl[i].exp_valid));
      check($sformatf("vec%0d_err", i), int'(bus.oErr), 0);
    end

    // Auto scan over mask 1010_0101
    bus.iMode = 1'b1; bus.iMask = 8'hA5; bus.iReady = 1'b1; set_data(8'hF0);
    ns = 0; last_t = 0;
    for (int t = 1; t <= 40 && ns < 5; t++) begin
      tick();
      if (bus.oValid) begin
        check("auto_chan", int'(bus.oChan), exp_seq[ns]);
        check("auto_data", int'(bus.oData), 'hF0 + exp_seq[ns]);
        if (ns == 0) check("auto_first", t, 5);
        else check("auto_gap", t - last_t, 4);
        last_t = t;
        ns++;
      end
    end
    check("auto_count", ns, 5);

    // Empty mask, then single channel 6
    bus.iMask = 8'h00;
    for (int t = 0; t < 20; t++) begin
      tick();
      check("mask0_valid", int'(bus.oValid), 0);
    end
    bus.iMask = 8'h40;
    n6 = 0;
    for (int t = 1; t <= 24; t++) begin
      tick();
      if (bus.oValid) begin
        check("mask6_chan", int'(bus.oChan), 6);
        if (n6 == 0) check("mask6_first", t, 2);
        n6++;
      end
    end
    check("mask6_count", n6, 6);

    // Reset in the middle of a stall
    bus.iMask = 8'hA5; bus.iReady = 1'b0;
    t_valid = 0;
    for (int t = 1; t <= 20 && t_valid == 0; t++) begin
      tick();
      if (bus.oValid) t_valid = t;
    end
    check("stall_wait", (t_valid != 0) ? 1 : 0, 1);
    tick();
    check("stall_hold", int'(bus.oValid), 1);
    #3 rst = 1'b1;
    #1;
    check("arst_data", int'(bus.oData), 0);
    check("arst_chan", int'(bus.oChan), 0);
    check("arst_valid", int'(bus.oValid), 0);
    check("arst_err", int'(bus.oErr), 0);
    #1 rst = 1'b0;
    model_reset();
    bus.iReady = 1'b1;
    t_valid = 0;
    for (int t = 1; t <= 20 && t_valid == 0; t++) begin
      tick();
      if (bus.oValid) t_valid = t;
    end
    check("restart_time", t_valid, 4);
    check("restart_chan", int'(bus.oChan), 0);

    // Six-channel instance: out-of-range select and dwell 1
    for (int k = 0; k < 6; k++) bus6.iData[k*8 +: 8] = 8'hA0 + 8'(k);
    bus6.iMode = 1'b0; bus6.iReady = 1'b1; bus6.iSel = 3'd2;
    tick();
    check("oor_pre_data", int'(bus6.oData), 'hA2);
    check("oor_pre_valid", int'(bus6.oValid), 1);
    bus6.iSel = 3'd7;
    tick();
    check("oor_err", int'(bus6.oErr), 1);
    check("oor_valid", int'(bus6.oValid), 0);
    check("oor_data", int'(bus6.oData), 'hA2);
    check("oor_chan", int'(bus6.oChan), 2);
    bus6.iSel = 3'd1;
    tick();
    check("oor_err_clr", int'(bus6.oErr), 0);
    check("oor_post_chan", int'(bus6.oChan), 1);
    check("oor_post_valid", int'(bus6.oValid), 1);
    bus6.iMode = 1'b1; bus6.iMask = 6'h3F;
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      check("d1_valid", int'(bus6.oValid), 1);
      check("d1_chan", int'(bus6.oChan), i % 6);
      check("d1_data", int'(bus6.oData), 'hA0 + (i % 6));
    end

    // Randomized traffic against the model
    @(negedge clk);
    rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(15) == 0) bus.iMode = ~bus.iMode;
      bus.iSel = 3'($urandom_range(7));
      if ($urandom_range(7) == 0) bus.iMask = 8'($urandom_range(255));
      bus.iReady = ($urandom_range(3) != 0);
      bus.iData = {$urandom, $urandom};
      tick();
      check("rnd_valid", int'(bus.oValid), m_valid);
      check("rnd_err", int'(bus.oErr), m_err);
      check("rnd_chan", int'(bus.oChan), m_chan);
      check("rnd_data", int'(bus.oData), m_data);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
